// File: rtl/memory_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : memory_bus_responder
// Description : Memory-side responder for the relay computer control FSM.
//               Serves read/write strobes against an internal word memory
//               with a fixed read latency, flags illegal requests and keeps
//               the instruction register that feeds opcode bits to the FSM.
// Ports       : clock, reset          - clock and synchronous active-high reset
//               address_bus           - request address
//               mem_read / mem_write  - request strobes from the FSM
//               data_bus_in           - write data
//               ld_inst               - load instruction register strobe
//               data_bus_out          - registered read data (held between reads)
//               data_valid            - one-cycle pulse on new read data
//               ack                   - one-cycle write confirmation
//               busy                  - read in flight
//               bus_error             - one-cycle pulse on both strobes in IDLE
//               instruction_bits      - top four bits of the instruction register
// Revision    : 1.0 - initial release
// ============================================================================
module memory_bus_responder #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_WORDS    = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_bus,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  input  logic                  ld_inst,
  output logic [DATA_WIDTH-1:0] data_bus_out,
  output logic                  data_valid,
  output logic                  ack,
  output logic                  busy,
  output logic                  bus_error,
  output logic [3:0]            instruction_bits
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  // One extra bit so an address equal to 2**ADDR_WIDTH-1 still compares sanely.
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);
  localparam logic [CNT_W-1:0]    CNT_START = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    READ_WAIT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    data_valid_q, data_valid_d;
  logic                    ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic                    bus_error_q, bus_error_d;
  logic [3:0]              inst_q, inst_d;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];
  logic                    mem_we;
  logic                    req_in_range;
  logic                    rd_in_range;
  logic [DATA_WIDTH-1:0]   rd_data;

  assign req_in_range = ({1'b0, address_bus} < MEM_LIMIT);
  assign rd_in_range  = ({1'b0, addr_q} < MEM_LIMIT);
  // Memory is sampled at the data edge, not at acceptance; writes cannot
  // intervene because they are ignored while a read is pending.
  assign rd_data      = rd_in_range ? mem_q[addr_q[IDX_W-1:0]] : '0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_out_d   = data_out_q;
    busy_d       = busy_q;
    data_valid_d = 1'b0;
    ack_d        = 1'b0;
    bus_error_d  = 1'b0;
    mem_we       = 1'b0;
    // Loads the value held before this edge, independent of FSM state.
    inst_d       = ld_inst ? data_out_q[DATA_WIDTH-1:DATA_WIDTH-4] : inst_q;

    case (state_q)
      IDLE: begin
        if (mem_read && mem_write) begin
          bus_error_d = 1'b1;
        end else if (mem_read) begin
          state_d = READ_WAIT;
          addr_d  = address_bus;
          cnt_d   = CNT_START;
          busy_d  = 1'b1;
        end else if (mem_write) begin
          // Out-of-range writes are acknowledged but dropped.
          ack_d  = 1'b1;
          mem_we = req_in_range;
        end
      end
      READ_WAIT: begin
        // Strobes are deliberately ignored here.
        if (cnt_q == '0) begin
          data_out_d   = rd_data;
          data_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      bus_error_q  <= 1'b0;
      inst_q       <= 4'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      bus_error_q  <= bus_error_d;
      inst_q       <= inst_d;
    end
  end

  // Storage survives reset; reset only blocks a coincident write.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem_q[address_bus[IDX_W-1:0]] <= data_bus_in;
    end
  end

  assign data_bus_out     = data_out_q;
  assign data_valid       = data_valid_q;
  assign ack              = ack_q;
  assign busy             = busy_q;
  assign bus_error        = bus_error_q;
  assign instruction_bits = inst_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_bus_responder
// Description : Self-checking bench for memory_bus_responder with a
//               behavioural memory model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_bus_responder;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MW = 256;
  localparam int RL = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address_bus;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] data_bus_in;
  logic          ld_inst;
  logic [DW-1:0] data_bus_out;
  logic          data_valid;
  logic          ack;
  logic          busy;
  logic          bus_error;
  logic [3:0]    instruction_bits;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_mem [MW];

  memory_bus_responder #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MEM_WORDS   (MW),
    .READ_LATENCY(RL)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .address_bus     (address_bus),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .data_bus_in     (data_bus_in),
    .ld_inst         (ld_inst),
    .data_bus_out    (data_bus_out),
    .data_valid      (data_valid),
    .ack             (ack),
    .busy            (busy),
    .bus_error       (bus_error),
    .instruction_bits(instruction_bits)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] model_read(input int addr);
    return (addr < MW) ? model_mem[addr] : '0;
  endfunction

  // Issues one read and records what the DUT shows over a bounded window.
  // Sample index 1 is just after the acceptance edge.
  task automatic read_observe(input logic [AW-1:0] a, output int busy_cyc,
                              output int dv_at, output int dv_cnt,
                              output logic [DW-1:0] data);
    busy_cyc = 0; dv_at = 0; dv_cnt = 0; data = '0;
    address_bus = a; mem_read = 1'b1; mem_write = 1'b0;
    step();
    mem_read = 1'b0; address_bus = AW'($urandom);
    for (int i = 1; i <= RL + 4; i++) begin
      if (i > 1) step();
      if (busy === 1'b1) busy_cyc++;
      if (data_valid === 1'b1) begin
        dv_cnt++;
        if (dv_at == 0) begin dv_at = i; data = data_bus_out; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; ld_inst = 1'b0;
    address_bus = '0; data_bus_in = '0;
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    checks++; if (data_bus_out !== '0) begin failures++; $display("FAIL reset_data got=%h exp=00", data_bus_out); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", data_valid); end
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL reset_berr got=%b exp=0", bus_error); end
    checks++; if (instruction_bits !== 4'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", instruction_bits); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    for (int i = 0; i < MW; i++) begin
      d = DW'($urandom);
      address_bus = AW'(i); data_bus_in = d; mem_write = 1'b1;
      step();
      model_mem[i] = d;
      checks++; if (ack !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_ack addr=%0d got ack=%b busy=%b exp ack=1 busy=0", i, ack, busy); end
    end
    mem_write = 1'b0;
    step();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL b2b_ack_drop got=%b exp=0", ack); end
  endtask

  task automatic test_write_read();
    int bc, dva, dvc; logic [DW-1:0] d;
    address_bus = 16'h0010; data_bus_in = 8'hA5; mem_write = 1'b1;
    step();
    mem_write = 1'b0; model_mem[16'h10] = 8'hA5;
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wr_ack got=%b exp=1", ack); end
    step();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wr_ack_pulse got=%b exp=0", ack); end
    read_observe(16'h0010, bc, dva, dvc, d);
    checks++; if (bc != RL) begin failures++; $display("FAIL rd_busy_cycles got=%0d exp=%0d", bc, RL); end
    checks++; if (dva != RL + 1) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", dva, RL + 1); end
    checks++; if (dvc != 1) begin failures++; $display("FAIL rd_dv_pulses got=%0d exp=1", dvc); end
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h exp=a5", d); end
    checks++; if (data_bus_out !== 8'hA5) begin failures++; $display("FAIL rd_data_hold got=%h exp=a5", data_bus_out); end
    ld_inst = 1'b1;
    step();
    ld_inst = 1'b0;
    checks++; if (instruction_bits !== 4'hA) begin failures++; $display("FAIL ld_inst got=%h exp=a", instruction_bits); end
    // Read sampled the cycle right after a write sees the new value.
    address_bus = 16'h0011; data_bus_in = 8'h5A; mem_write = 1'b1;
    step();
    mem_write = 1'b0; model_mem[16'h11] = 8'h5A;
    read_observe(16'h0011, bc, dva, dvc, d);
    checks++; if (d !== 8'h5A || dva != RL + 1) begin failures++; $display("FAIL raw_data got=%h@%0d exp=5a@%0d", d, dva, RL + 1); end
  endtask

  task automatic test_ignore_in_wait();
    address_bus = 16'h0010; mem_read = 1'b1;
    step();                                   // read accepted
    mem_write = 1'b1; data_bus_in = 8'hFF;    // read still held
    step();
    checks++; if (ack !== 1'b0 || bus_error !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL wait_ignore got ack=%b berr=%b busy=%b exp 0 0 1", ack, bus_error, busy); end
    mem_write = 1'b0;
    step();
    checks++; if (data_valid !== 1'b1 || data_bus_out !== 8'hA5 || ack !== 1'b0) begin failures++; $display("FAIL wait_data got dv=%b data=%h ack=%b exp 1 a5 0", data_valid, data_bus_out, ack); end
    step();                                   // held read re-accepted
    checks++; if (busy !== 1'b1 || data_valid !== 1'b0) begin failures++; $display("FAIL reaccept got busy=%b dv=%b exp 1 0", busy, data_valid); end
    mem_read = 1'b0;
    for (int i = 0; i < RL; i++) step();
    checks++; if (data_valid !== 1'b1 || data_bus_out !== 8'hA5) begin failures++; $display("FAIL reaccept_data got dv=%b data=%h exp 1 a5", data_valid, data_bus_out); end
    step();
  endtask

  task automatic test_bus_error();
    int bc, dva, dvc; logic [DW-1:0] d;
    address_bus = 16'h0010; data_bus_in = 8'h3C; mem_read = 1'b1; mem_write = 1'b1;
    step();
    mem_read = 1'b0; mem_write = 1'b0;
    checks++; if (bus_error !== 1'b1 || ack !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL berr got berr=%b ack=%b busy=%b exp 1 0 0", bus_error, ack, busy); end
    step();
    checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL berr_pulse got=%b exp=0", bus_error); end
    read_observe(16'h0010, bc, dva, dvc, d);
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL berr_mem got=%h exp=a5", d); end
  endtask

  task automatic test_out_of_range();
    int bc, dva, dvc; logic [DW-1:0] d;
    read_observe(16'h0100, bc, dva, dvc, d);
    checks++; if (d !== 8'h00 || dva != RL + 1 || bc != RL) begin failures++; $display("FAIL oor_read got=%h@%0d busy=%0d exp=00@%0d busy=%0d", d, dva, bc, RL + 1, RL); end
    address_bus = 16'h0100; data_bus_in = 8'h55; mem_write = 1'b1;
    step();
    mem_write = 1'b0;
    checks++; if (ack !== 1'b1 || bus_error !== 1'b0) begin failures++; $display("FAIL oor_ack got ack=%b berr=%b exp 1 0", ack, bus_error); end
    read_observe(16'h0100, bc, dva, dvc, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL oor_reread got=%h exp=00", d); end
    read_observe(16'h0000, bc, dva, dvc, d);
    checks++; if (d !== model_mem[0]) begin failures++; $display("FAIL oor_alias got=%h exp=%h", d, model_mem[0]); end
  endtask

  task automatic test_ld_inst_timing();
    int bc, dva, dvc; logic [DW-1:0] d;
    read_observe(16'h0010, bc, dva, dvc, d);   // data_bus_out now a5
    address_bus = 16'h0020; data_bus_in = 8'h3C; mem_write = 1'b1;
    step();
    mem_write = 1'b0; model_mem[16'h20] = 8'h3C;
    mem_read = 1'b1; ld_inst = 1'b1;
    step();
    mem_read = 1'b0;
    checks++; if (instruction_bits !== 4'hA) begin failures++; $display("FAIL ldi_idle got=%h exp=a", instruction_bits); end
    for (int i = 0; i < RL; i++) step();
    checks++; if (data_valid !== 1'b1 || instruction_bits !== 4'hA) begin failures++; $display("FAIL ldi_old got dv=%b inst=%h exp 1 a", data_valid, instruction_bits); end
    step();
    ld_inst = 1'b0;
    checks++; if (instruction_bits !== 4'h3) begin failures++; $display("FAIL ldi_new got=%h exp=3", instruction_bits); end
  endtask

  task automatic test_reset_during_read();
    int bc, dva, dvc, dv_seen; logic [DW-1:0] d;
    address_bus = 16'h0010; mem_read = 1'b1;
    step();
    mem_read = 1'b0; reset = 1'b1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_rd_busy got=%b exp=1", busy); end
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || data_valid !== 1'b0 || data_bus_out !== '0) begin failures++; $display("FAIL rst_rd_abort got busy=%b dv=%b data=%h exp 0 0 00", busy, data_valid, data_bus_out); end
    dv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (data_valid === 1'b1 || busy === 1'b1) dv_seen++;
    end
    checks++; if (dv_seen != 0) begin failures++; $display("FAIL rst_rd_quiet got=%0d exp=0", dv_seen); end
    read_observe(16'h0010, bc, dva, dvc, d);
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL rst_mem_kept got=%h exp=a5", d); end
  endtask

  task automatic test_random();
    int bc, dva, dvc, a; logic [DW-1:0] d, e;
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, 319));
      if ($urandom_range(0, 1) == 0) begin
        d = DW'($urandom);
        address_bus = AW'(a); data_bus_in = d; mem_write = 1'b1;
        step();
        mem_write = 1'b0;
        if (a < MW) model_mem[a] = d;
        checks++; if (ack !== 1'b1 || bus_error !== 1'b0) begin failures++; $display("FAIL rnd_wr addr=%0d got ack=%b berr=%b exp 1 0", a, ack, bus_error); end
      end else begin
        e = model_read(a);
        read_observe(AW'(a), bc, dva, dvc, d);
        checks++; if (d !== e || dva != RL + 1 || dvc != 1 || bc != RL) begin failures++; $display("FAIL rnd_rd addr=%0d got=%h@%0d dv=%0d busy=%0d exp=%h@%0d dv=1 busy=%0d", a, d, dva, dvc, bc, e, RL + 1, RL); end
        ld_inst = 1'b1;
        step();
        ld_inst = 1'b0;
        checks++; if (instruction_bits !== e[DW-1:DW-4]) begin failures++; $display("FAIL rnd_inst got=%h exp=%h", instruction_bits, e[DW-1:DW-4]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_write_read();
    test_ignore_in_wait();
    test_bus_error();
    test_out_of_range();
    test_ld_inst_timing();
    test_reset_during_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_bus_responder.md
# memory_bus_responder

- Memory-side responder for the relay computer's control FSM.
- Answers the FSM's memory read/write strobes on the address and data buses with a fixed, parameterised read latency.
- Holds the instruction register that supplies `instruction_bits` back to the FSM.
- Sits between the FSM/address-bus logic and program/data memory, so behavioural CPU models can run real instruction streams instead of hand-driven opcode bits.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: width of `address_bus`.
- `DATA_WIDTH`, 8: width of the data buses (≥ 4).
- `MEM_WORDS`, 256: implemented storage words at addresses 0..MEM_WORDS-1.
- `READ_LATENCY`, 2: edges from read acceptance to `data_valid` (≥ 1).

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address_bus`  in  ADDR_WIDTH  address of the current request.
- `mem_read`  in  1  read strobe from the FSM.
- `mem_write`  in  1  write strobe from the FSM.
- `data_bus_in`  in  DATA_WIDTH  write data.
- `ld_inst`  in  1  load-instruction-register strobe.
- `data_bus_out`  out  DATA_WIDTH  registered read data; holds its value between reads.
- `data_valid`  out  1  one-cycle pulse when `data_bus_out` carries new read data.
- `ack`  out  1  one-cycle pulse confirming a write.
- `busy`  out  1  high while a read is in flight.
- `bus_error`  out  1  one-cycle pulse on an illegal request.
- `instruction_bits`  out  4  instruction register MSBs, fed to the FSM.

## Operation
- States: IDLE, READ_WAIT.
- IDLE, `mem_read` only:
  - Latch the address and go to READ_WAIT with the latency counter at READ_LATENCY-1.
  - Raise `busy`.
- IDLE, `mem_write` only:
  - Write `data_bus_in` to memory at that edge.
  - Pulse `ack`. State stays IDLE.
- IDLE, both strobes high:
  - No memory access.
  - Pulse `bus_error`. State stays IDLE.
- READ_WAIT:
  - Decrement the counter each edge.
  - When the counter is 0, load `data_bus_out` from memory at the latched address and pulse `data_valid`.
  - Drop `busy` and return to IDLE.
- Strobes that arrive in READ_WAIT are ignored: no queueing, no `bus_error`. The FSM must wait for `data_valid`.
- Read data comes from memory at the moment of the data edge. A write that lands between acceptance and data is impossible, because writes are ignored in READ_WAIT.
- Out of range (address ≥ MEM_WORDS):
  - Reads return 0 with normal timing.
  - Writes are discarded but still acknowledged.
  - `bus_error` is not raised.
- `ld_inst` high at an edge: `instruction_bits` <= `data_bus_out[DATA_WIDTH-1:DATA_WIDTH-4]`, using the value held before that edge. It may coincide with any state or request.
- Reset:
  - State goes to IDLE.
  - `data_bus_out` = 0, `data_valid` = 0, `ack` = 0, `busy` = 0, `bus_error` = 0, `instruction_bits` = 0.
  - Memory contents are not cleared.
  - Reset during READ_WAIT aborts the read; no `data_valid` follows.
  - Reset dominates every other input at the same edge.

## Timing
- Read accepted at edge E0:
  - `busy` high after E0.
  - Data edge at E0+READ_LATENCY. At that edge `data_valid` goes high and `data_bus_out` updates, and `busy` goes low.
  - `data_valid` falls at E0+READ_LATENCY+1.
- Next read can be accepted no earlier than E0+READ_LATENCY+1. Maximum rate is one read per READ_LATENCY+1 cycles.
- With READ_LATENCY = 1, `busy` is high for exactly one cycle.
- Write sampled at E0:
  - Memory updated at E0. `ack` high for the cycle after E0.
  - Back-to-back writes are allowed every cycle.
  - A read sampled at E0+1 to the same address returns the new value.
- `data_valid`, `ack` and `bus_error` are never high for more than one consecutive cycle unless a new request is accepted.
- The FSM asserts `ld_inst` in the cycle `data_valid` is high. `instruction_bits` updates at the following edge.

## Test plan
- Reset, then idle 3 cycles -> all outputs 0, `busy` = 0.
- Write 0xA5 to address 0x0010 (`ack` one cycle after), then read 0x0010 with READ_LATENCY = 2 -> `busy` high 2 cycles, `data_bus_out` = 0xA5 with a one-cycle `data_valid`. Then assert `ld_inst` -> `instruction_bits` = 4'b1010.
- Read 0x0010 accepted; `mem_read` held high and `mem_write` of 0xFF to 0x0010 pulsed during READ_WAIT -> both ignored, returned data 0xA5, no `ack`. Held `mem_read` is re-accepted one cycle after `data_valid`.
- Both strobes high in IDLE -> `bus_error` one cycle, memory unchanged, no `ack` or `busy`.
- Read 0x0100 with MEM_WORDS = 256 -> 0x00 with normal latency. Write 0x55 to 0x0100 -> `ack` pulses, later read still 0x00.
- Reset asserted one cycle into a read -> `busy` = 0 after the edge, no `data_valid` in the following 4 cycles, address 0x0010 still reads 0xA5.
